fnd_scan_cntr: RTL
==================

Name: fnd_scan_cntr

Overview:
- Drives a 4-digit common-anode seven-segment (FND) display from a 12-bit binary value.
- Converts the value to BCD with a sequential shift-add-3 FSM, one bit per clock, or passes it through as hex.
- Time-multiplexes the four digits through a shared segment decoder.
- Sits between application logic (watch/counter) and the board FND pins.

Parameters:
- SCAN_DIV, 100000, clocks per digit slot (1 ms at 100 MHz); minimum 2.
- CNT_W, 17, width of the scan prescaler; must hold SCAN_DIV-1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- value  input  12  binary value to display
- value_valid  input  1  one-cycle strobe; samples value and hex_mode
- hex_mode  input  1  1 = show value as 3 hex digits (digit3 = 0); 0 = decimal
- blank_lz  input  1  1 = blank leading zero digits (decimal mode only)
- dp_en  input  4  decimal point enable per digit, bit i = digit i
- busy  output  1  conversion in progress
- seg  output  8  segments, active-low, bit order p g f e d c b a
- com  output  4  digit enables, active-low, bit i = digit i (digit0 = rightmost)

Behaviour:
- Reset, asynchronous on reset_n low:
  - seg = 8'hFF, com = 4'b1111, busy = 0.
  - Display register = 16'h0000, digit index = 0, prescaler = 0.
  - FSM = IDLE, pending flag cleared.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: on value_valid, latch value and hex_mode. If decimal, clear BCD accumulator, go to SHIFT, busy = 1. If hex, go to LOAD.
  - SHIFT: 12 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by one, inserting the latched value bit, MSB first. After the 12th shift, go to LOAD.
  - LOAD: one cycle. Display register <= BCD result, or {4'h0, latched value} in hex mode. busy = 0 on the following cycle. Return to IDLE.
- Latency:
  - Decimal: strobe at cycle 0 -> display register updated at the end of cycle 13.
  - Hex: strobe at cycle 0 -> display register updated at the end of cycle 1.
- value_valid while busy: value and hex_mode go to a pending register and the pending flag is set; the latest strobe wins. After LOAD, the FSM restarts from the pending data without passing through an IDLE wait. The current conversion is never aborted.
- The display register changes only in LOAD, so no partially converted digit is ever shown.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the wrap, digit index advances 0->1->2->3->0.
  - Ghost suppression: on the cycle the index changes, com = 4'b1111. On every other cycle, com = ~(4'b0001 << index).
- Segment data is registered; com and seg change on the same edge.
  - seg[6:0] = decoded nibble for the selected digit, patterns 0-F, active-low.
  - seg[7] = ~dp_en[index].
- Leading-zero blanking (decimal, blank_lz = 1):
  - Digit i is blanked (seg[6:0] = 7'h7F) if it and every higher digit are 0.
  - Digit0 is never blanked.
  - The dp of a blanked digit still follows dp_en.
  - blank_lz, dp_en and hex_mode display are evaluated live each cycle. hex_mode for conversion is sampled at value_valid.
- Values up to 4095 fit in 4 BCD digits; no overflow indication is needed.
- Reset mid-conversion: everything returns to reset values; the pending value is discarded.

Test Plan:
- Bench uses SCAN_DIV = 4.
- Reset: hold reset_n = 0 with clk running -> seg = 8'hFF, com = 4'b1111, busy = 0. After release, digit 0 shows "0": seg = 8'hC0 while com = 4'b1110.
- Decimal conversion: value = 12'd1234, hex_mode = 0, one strobe -> busy high for 13 cycles. Over one scan frame, digits 3..0 show seg 8'hF9, 8'hA4, 8'hB0, 8'h99.
- Boundary values, decimal: 4095 -> 4,0,9,5. 0 -> 0,0,0,0. Hex mode, value = 12'hABC -> digits 3..0 = 0, A, b, C (seg 8'hC0, 8'h88, 8'h83, 8'hC6), available 2 cycles after the strobe.
- Back-to-back: strobe 12'd100, then 12'd7 at cycle 3, then 12'd42 at cycle 5 -> display shows 100, then 42. The value 7 is never displayed; busy stays high continuously until 42 loads.
- Blanking/dp: value 12'd5, blank_lz = 1, dp_en = 4'b0010 -> digits 3 and 2 show seg 8'hFF, digit1 shows 8'h7F, digit0 shows 8'h92. With blank_lz = 0 -> digits 3..1 show zero patterns.
- Scan timing: every digit transition has exactly one cycle with com = 4'b1111. Each digit is active for 3 of 4 cycles. Assert reset_n low mid-SHIFT -> busy = 0 immediately, and the display register reads 0 after release.

Source files
------------

// File: rtl/fnd_scan_cntr_if.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_cntr_if
// Description : Application-side bundle for the FND scan controller: value
//               strobe and display options in, busy flag and FND pins out.
// Revision    : 1.0 - initial release
// ============================================================================
interface fnd_scan_cntr_if;
  logic [11:0] value;
  logic        value_valid;
  logic        hex_mode;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  com;

  // Application logic drives the value and display options
  modport master (
    output value, value_valid, hex_mode, blank_lz, dp_en,
    input  busy, seg, com
  );

  // The scan controller consumes them and drives the board pins
  modport slave (
    input  value, value_valid, hex_mode, blank_lz, dp_en,
    output busy, seg, com
  );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_cntr.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_cntr
// Description : 4-digit common-anode seven-segment driver. Converts a 12-bit
//               value to BCD (shift-add-3, one bit per clock) or shows it as
//               hex, then time-multiplexes the digits through one decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_cntr #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input wire             clk,
  input wire             reset_n,
  fnd_scan_cntr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_start;
  logic [11:0]      w_start_val;
  logic             w_start_hex;
  logic             w_shift;
  logic             w_load;

  logic [11:0]      r_val;
  logic             r_hex;
  logic [11:0]      r_pend_val;
  logic             r_pend_hex;
  logic             r_pend;
  logic [15:0]      r_bcd;
  logic [3:0]       r_bit_cnt;
  logic [15:0]      r_disp;
  logic             r_busy;
  logic [11:0]      w_adj;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             w_wrap;
  logic [7:0]       r_seg;
  logic [3:0]       r_com;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero;
  logic [3:0]       w_lz;
  logic             w_blank;

  // Active-low gfedcba pattern for a hex nibble
  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'h0: f_dec = 7'h40;
      4'h1: f_dec = 7'h79;
      4'h2: f_dec = 7'h24;
      4'h3: f_dec = 7'h30;
      4'h4: f_dec = 7'h19;
      4'h5: f_dec = 7'h12;
      4'h6: f_dec = 7'h02;
      4'h7: f_dec = 7'h78;
      4'h8: f_dec = 7'h00;
      4'h9: f_dec = 7'h10;
      4'hA: f_dec = 7'h08;
      4'hB: f_dec = 7'h03;
      4'hC: f_dec = 7'h46;
      4'hD: f_dec = 7'h21;
      4'hE: f_dec = 7'h06;
      default: f_dec = 7'h0E;
    endcase
  endfunction

  // Conversion FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state; LOAD restarts straight from a newer strobe or the pending slot
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_start_val = bus.value;
    w_start_hex = bus.hex_mode;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.value_valid) begin
          w_start = 1'b1;
          w_next  = bus.hex_mode ? S_LOAD : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == 4'd11) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        if (bus.value_valid || r_pend) begin
          w_start     = 1'b1;
          w_start_val = bus.value_valid ? bus.value    : r_pend_val;
          w_start_hex = bus.value_valid ? bus.hex_mode : r_pend_hex;
          w_next      = w_start_hex ? S_LOAD : S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 on the lower three BCD nibbles; the top one never exceeds 4
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                              r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
  end

  // Conversion datapath, pending slot and display register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val      <= 12'h000;
      r_hex      <= 1'b0;
      r_pend_val <= 12'h000;
      r_pend_hex <= 1'b0;
      r_pend     <= 1'b0;
      r_bcd      <= 16'h0000;
      r_bit_cnt  <= 4'd0;
      r_disp     <= 16'h0000;
      r_busy     <= 1'b0;
    end else begin
      if (w_start) begin
        r_val     <= w_start_val;
        r_hex     <= w_start_hex;
        r_bcd     <= 16'h0000;
        r_bit_cnt <= 4'd0;
        r_busy    <= ~w_start_hex;
      end else if (w_shift) begin
        r_bcd     <= {r_bcd[14:12], w_adj, r_val[11]};
        r_val     <= {r_val[10:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else if (w_load) begin
        r_busy    <= 1'b0;
      end

      if (w_load) r_disp <= r_hex ? {4'h0, r_val} : r_bcd;

      // A strobe in LOAD is consumed directly, so the slot only fills in SHIFT
      if (w_load) begin
        r_pend <= 1'b0;
      end else if (bus.value_valid && (r_state == S_SHIFT)) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.value;
        r_pend_hex <= bus.hex_mode;
      end
    end
  end

  assign w_wrap = (r_cnt == c_cnt_last);
  assign w_nib  = r_disp[{r_idx, 2'b00} +: 4];

  assign w_zero[0] = (r_disp[3:0]   == 4'h0);
  assign w_zero[1] = (r_disp[7:4]   == 4'h0);
  assign w_zero[2] = (r_disp[11:8]  == 4'h0);
  assign w_zero[3] = (r_disp[15:12] == 4'h0);
  assign w_lz[3]   = w_zero[3];
  assign w_lz[2]   = w_zero[3] & w_zero[2];
  assign w_lz[1]   = w_zero[3] & w_zero[2] & w_zero[1];
  assign w_lz[0]   = 1'b0;
  assign w_blank   = bus.blank_lz & ~bus.hex_mode & w_lz[r_idx];

  // Prescaler and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered pins; all digits are off for the cycle the index moves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= 8'hFF;
      r_com <= 4'b1111;
    end else if (w_wrap) begin
      r_seg <= 8'hFF;
      r_com <= 4'b1111;
    end else begin
      r_seg <= {~bus.dp_en[r_idx], (w_blank ? 7'h7F : f_dec(w_nib))};
      r_com <= ~(4'b0001 << r_idx);
    end
  end

  assign bus.busy = r_busy;
  assign bus.seg  = r_seg;
  assign bus.com  = r_com;

endmodule
`default_nettype wire
